afifo_gray: RTL

//  Parametrised dual-clock FIFO for CDC data transfer between wclk and rclk domains.

---
 rtl/afifo_gray.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/afifo_gray.sv
// Dual-clock FIFO: Gray-coded pointers cross through SYNC_STAGES-deep synchronisers, registered read data.
// Optional sticky overflow/underflow flags (ovf/udf) are built when AFIFO_ERR_EN is defined.
module afifo_gray #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count
`ifdef AFIFO_ERR_EN
    ,
    output logic                  ovf,
    output logic                  udf
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_T  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_T = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [ADDR_WIDTH:0] wbin_reg, wgray_reg, wbin_next, rgray_sync;
    logic                wr_accept;

    assign wr_accept = wen && !full;
    assign wbin_next = wbin_reg + PTR_ONE;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
        end else if (wr_accept) begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wbin_next ^ (wbin_next >> 1);
        end
    end

    always_ff @(posedge wclk) begin
        if (wr_accept) begin
            mem[wbin_reg[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    // ---------------- read domain ----------------
    logic [ADDR_WIDTH:0]   rbin_reg, rgray_reg, rbin_next, wgray_sync;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  rvalid_reg, rd_accept;

    assign rd_accept = ren && !empty;
    assign rbin_next = rbin_reg + PTR_ONE;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_reg   <= '0;
            rgray_reg  <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= rd_accept;
            if (rd_accept) begin
                rbin_reg  <= rbin_next;
                rgray_reg <= rbin_next ^ (rbin_next >> 1);
                rdata_reg <= mem[rbin_reg[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Only registered Gray values enter a chain; each chain is cleared by its destination reset.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_rsync
            logic [ADDR_WIDTH:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge wclk) begin
                    if (!wrst_n) stage_reg <= '0;
                    else         stage_reg <= rgray_reg;
                end
            end else begin : g_next
                always_ff @(posedge wclk) begin
                    if (!wrst_n) stage_reg <= '0;
                    else         stage_reg <= g_rsync[gi-1].stage_reg;
                end
            end
        end

        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_wsync
            logic [ADDR_WIDTH:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge rclk) begin
                    if (!rrst_n) stage_reg <= '0;
                    else         stage_reg <= wgray_reg;
                end
            end else begin : g_next
                always_ff @(posedge rclk) begin
                    if (!rrst_n) stage_reg <= '0;
                    else         stage_reg <= g_wsync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign rgray_sync = g_rsync[SYNC_STAGES-1].stage_reg;
    assign wgray_sync = g_wsync[SYNC_STAGES-1].stage_reg;

    // Flags and counts decode local registers only, so they stay glitch-free and pessimistic.
    assign full = (wgray_reg == {~rgray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rgray_sync[ADDR_WIDTH-2:0]});
    assign wr_count    = wbin_reg - gray2bin(rgray_sync);
    assign almost_full = (wr_count >= AFULL_T);

    assign empty        = (rgray_reg == wgray_sync);
    assign rd_count     = gray2bin(wgray_sync) - rbin_reg;
    assign almost_empty = (rd_count <= AEMPTY_T);

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;

`ifdef AFIFO_ERR_EN
    logic ovf_reg, udf_reg;

    always_ff @(posedge wclk) begin
        if (!wrst_n)          ovf_reg <= 1'b0;
        else if (wen && full) ovf_reg <= 1'b1;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n)           udf_reg <= 1'b0;
        else if (ren && empty) udf_reg <= 1'b1;
    end

    assign ovf = ovf_reg;
    assign udf = udf_reg;
`endif

endmodule
